// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the operand-B mux and ALU: latches a request, steers the mux,
// runs the ALU for EXEC_CYCLES cycles and holds the result until the consumer takes it.
module alu_sequencer #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OPCODE,
  input  logic             IMM_SEL,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [WIDTH-1:0] IMM,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             ERR,
  output logic             MUX_SEL,
  output logic [2:0]       ALU_SEL,
  output logic             BUSY
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StExec = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam int         ExecEff = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam logic [3:0] CntLoad = 4'(ExecEff - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             imm_sel_q, imm_sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_err;
  logic             alu_zero;

  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op_q)
      3'd0: alu_res = b_q;
      3'd1: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      3'd2: alu_res = a_q & b_q;
      3'd3: alu_res = a_q | b_q;
      default: alu_err = 1'b1;
    endcase
    alu_zero = !alu_err && (alu_res == '0);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    data2_d   = data2_q;
    imm_d     = imm_q;
    b_d       = b_q;
    op_d      = op_q;
    imm_sel_d = imm_sel_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        if (IN_VALID) begin
          a_d       = DATA1;
          data2_d   = DATA2;
          imm_d     = IMM;
          op_d      = OPCODE;
          imm_sel_d = IMM_SEL;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        b_d     = imm_sel_q ? imm_q : data2_q;
        cnt_d   = CntLoad;
        state_d = StExec;
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          result_d = alu_res;
          carry_d  = alu_carry;
          zero_d   = alu_zero;
          err_d    = alu_err;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (OUT_READY) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      data2_q   <= '0;
      imm_q     <= '0;
      b_q       <= '0;
      op_q      <= '0;
      imm_sel_q <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      data2_q   <= data2_d;
      imm_q     <= imm_d;
      b_q       <= b_d;
      op_q      <= op_d;
      imm_sel_q <= imm_sel_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
    end
  end

  // IN_READY is gated by RESET so it reads 0 for the whole reset window.
  assign IN_READY  = (state_q == StIdle) && !RESET;
  assign OUT_VALID = (state_q == StDone);
  assign BUSY      = (state_q != StIdle);
  assign MUX_SEL   = BUSY ? imm_sel_q : 1'b0;
  assign ALU_SEL   = BUSY ? op_q : 3'd0;
  assign RESULT    = result_q;
  assign CARRY     = carry_q;
  assign ZERO      = zero_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=4,
// sharing data inputs but with separate request valids.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid1, in_valid4;
  logic [2:0] opcode;
  logic       imm_sel;
  logic [7:0] data1, data2, imm;
  logic       out_ready;

  logic       in_ready1, out_valid1, carry1, zero1, err1, mux_sel1, busy1;
  logic [7:0] result1;
  logic [2:0] alu_sel1;
  logic       in_ready4, out_valid4, carry4, zero4, err4, mux_sel4, busy4;
  logic [7:0] result4;
  logic [2:0] alu_sel4;

  int n_chk  = 0;
  int n_fail = 0;

  alu_sequencer #(.WIDTH(8), .EXEC_CYCLES(1)) dut1 (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid1), .IN_READY(in_ready1), .OPCODE(opcode),
    .IMM_SEL(imm_sel), .DATA1(data1), .DATA2(data2), .IMM(imm), .OUT_VALID(out_valid1),
    .OUT_READY(out_ready), .RESULT(result1), .CARRY(carry1), .ZERO(zero1), .ERR(err1),
    .MUX_SEL(mux_sel1), .ALU_SEL(alu_sel1), .BUSY(busy1)
  );

  alu_sequencer #(.WIDTH(8), .EXEC_CYCLES(4)) dut4 (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid4), .IN_READY(in_ready4), .OPCODE(opcode),
    .IMM_SEL(imm_sel), .DATA1(data1), .DATA2(data2), .IMM(imm), .OUT_VALID(out_valid4),
    .OUT_READY(out_ready), .RESULT(result4), .CARRY(carry4), .ZERO(zero4), .ERR(err4),
    .MUX_SEL(mux_sel4), .ALU_SEL(alu_sel4), .BUSY(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction on dut1 with OUT_READY high; called and returns at a negedge.
  task automatic op1(input logic [2:0] op, input logic isel, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] im, input logic [7:0] exp_res,
                     input logic exp_c, input logic exp_z, input logic exp_e);
    in_valid1 = 1'b1; opcode = op; imm_sel = isel;
    data1 = a; data2 = b; imm = im; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after acceptance; the in-flight op must not see them.
    in_valid1 = 1'b0; opcode = 3'd1; imm_sel = ~isel;
    data1 = 8'h5A; data2 = 8'hC3; imm = 8'h96;
    chk("load_busy", busy1, 1);
    chk("load_in_ready", in_ready1, 0);
    chk("load_mux_sel", mux_sel1, isel);
    chk("load_alu_sel", alu_sel1, op);
    chk("load_out_valid", out_valid1, 0);
    @(negedge clk);
    chk("exec_out_valid", out_valid1, 0);
    chk("exec_mux_sel", mux_sel1, isel);
    @(negedge clk);
    chk("done_out_valid", out_valid1, 1);
    chk("done_in_ready", in_ready1, 0);
    chk("done_result", result1, exp_res);
    chk("done_carry", carry1, exp_c);
    chk("done_zero", zero1, exp_z);
    chk("done_err", err1, exp_e);
    chk("done_mux_sel", mux_sel1, isel);
    chk("done_alu_sel", alu_sel1, op);
    @(negedge clk);
    chk("idle_out_valid", out_valid1, 0);
    chk("idle_in_ready", in_ready1, 1);
    chk("idle_mux_sel", mux_sel1, 0);
    chk("idle_alu_sel", alu_sel1, 0);
    chk("idle_result_held", result1, exp_res);
  endtask

  // dut4 from the LOAD negedge: five non-valid cycles, then DONE with the given result.
  task automatic tail4(input logic [7:0] exp_res, input logic exp_c, input logic exp_z);
    for (int k = 0; k < 5; k++) begin
      chk("x4_out_valid_low", out_valid4, 0);
      chk("x4_busy", busy4, 1);
      @(negedge clk);
    end
    chk("x4_done_valid", out_valid4, 1);
    chk("x4_done_result", result4, exp_res);
    chk("x4_done_carry", carry4, exp_c);
    chk("x4_done_zero", zero4, exp_z);
  endtask

  initial begin
    logic saw_valid;
    rst = 1'b1; in_valid1 = 1'b0; in_valid4 = 1'b0; opcode = 3'd0; imm_sel = 1'b0;
    data1 = 8'h00; data2 = 8'h00; imm = 8'h00; out_ready = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", in_ready1, 0);
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_result", result1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready1, 1);
    chk("rel_in_ready4", in_ready4, 1);

    op1(3'd1, 1'b0, 8'h07, 8'h03, 8'hEE, 8'h0A, 1'b0, 1'b0, 1'b0);  // ADD reg
    op1(3'd1, 1'b1, 8'hFF, 8'h55, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);  // ADD imm wrap
    op1(3'd2, 1'b0, 8'h07, 8'h03, 8'hAA, 8'h03, 1'b0, 1'b0, 1'b0);  // AND
    op1(3'd3, 1'b0, 8'h07, 8'h03, 8'hAA, 8'h07, 1'b0, 1'b0, 1'b0);  // OR
    op1(3'd0, 1'b0, 8'h07, 8'h03, 8'hAA, 8'h03, 1'b0, 1'b0, 1'b0);  // FORWARD reg
    op1(3'd0, 1'b1, 8'h07, 8'h03, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);  // FORWARD imm
    op1(3'd5, 1'b0, 8'h07, 8'h03, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1);  // illegal
    op1(3'd2, 1'b1, 8'hF0, 8'h00, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);  // AND to zero

    // Reset while frozen in DONE: ADD F0+20 = 10 with carry.
    in_valid1 = 1'b1; opcode = 3'd1; imm_sel = 1'b1; data1 = 8'hF0; imm = 8'h20;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("frozen_valid", out_valid1, 1);
    chk("frozen_result", result1, 8'h10);
    chk("frozen_carry", carry1, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_result", result1, 0);
    chk("async_rst_carry", carry1, 0);
    chk("async_rst_out_valid", out_valid1, 0);
    chk("async_rst_mux_sel", mux_sel1, 0);
    chk("async_rst_alu_sel", alu_sel1, 0);
    chk("async_rst_busy", busy1, 0);
    chk("async_rst_in_ready", in_ready1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rerel_in_ready", in_ready1, 1);

    // Backpressure on dut4 with IN_VALID held and data churning.
    in_valid4 = 1'b1; opcode = 3'd1; imm_sel = 1'b0; data1 = 8'h10; data2 = 8'h20;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      data1 = 8'(k * 3); data2 = 8'(k + 9);
      chk("bp_out_valid_low", out_valid4, 0);
      chk("bp_in_ready_low", in_ready4, 0);
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      data1 = 8'(k + 1); data2 = 8'(k * 7); opcode = 3'(k);
      chk("bp_done_valid", out_valid4, 1);
      chk("bp_done_result", result4, 8'h30);
      chk("bp_done_in_ready", in_ready4, 0);
      @(negedge clk);
    end
    opcode = 3'd1; data1 = 8'h01; data2 = 8'h02; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready4, 1);
    chk("bp_idle_out_valid", out_valid4, 0);
    chk("bp_idle_result", result4, 8'h30);
    @(negedge clk);
    in_valid4 = 1'b0;
    chk("bp_reaccept_busy", busy4, 1);
    tail4(8'h03, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_end_idle", busy4, 0);

    // Reset in the second EXEC cycle.
    in_valid4 = 1'b1; opcode = 3'd3; imm_sel = 1'b0; data1 = 8'h0F; data2 = 8'hF0;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_out_valid", out_valid4, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid4) saw_valid = 1'b1;
    end
    chk("mid_rst_no_valid", saw_valid, 0);
    chk("mid_rst_result", result4, 0);

    in_valid4 = 1'b1; opcode = 3'd1; imm_sel = 1'b1; data1 = 8'h0F; imm = 8'hF1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    chk("post_rst_mux_sel", mux_sel4, 1);
    tail4(8'h00, 1'b1, 1'b1);
    @(negedge clk);
    chk("post_rst_idle", in_ready4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that owns and sequences the 8-bit operand-select mux and ALU datapath. It accepts one operation per request over a valid/ready handshake. It latches the operands, steers the operand-B mux between register data and immediate, runs the selected ALU function for a programmable number of cycles, and holds the result until the consumer acknowledges it. It sits between the instruction decode stage and the register-file write-back port.

## Interface
Parameters:
- WIDTH, 8, datapath width of operands and result
- EXEC_CYCLES, 1, cycles spent in EXEC (legal 1..15; values <1 behave as 1)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- IN_VALID  in  1  request valid
- IN_READY  out  1  controller can accept a request
- OPCODE  in  3  0:FORWARD 1:ADD 2:AND 3:OR, 4-7 illegal
- IMM_SEL  in  1  0: operand B = DATA2; 1: operand B = IMM
- DATA1  in  WIDTH  operand A
- DATA2  in  WIDTH  register operand B
- IMM  in  WIDTH  immediate operand B
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- RESULT  out  WIDTH  ALU result
- CARRY  out  1  carry-out of ADD
- ZERO  out  1  RESULT == 0 (legal opcodes only)
- ERR  out  1  illegal opcode flag
- MUX_SEL  out  1  operand-B mux select driven to datapath
- ALU_SEL  out  3  ALU function select driven to datapath
- BUSY  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, EXEC, DONE. The 4-bit down-counter CNT is used only in EXEC.
- IDLE: IN_READY=1. On an edge with IN_VALID&IN_READY: latch DATA1, DATA2, IMM, OPCODE, IMM_SEL, then go to LOAD.
- LOAD: MUX_SEL=latched IMM_SEL. Register the mux output (IMM_SEL ? IMM : DATA2) into the B operand register. Set CNT<=EXEC_CYCLES-1, then go to EXEC.
- EXEC: ALU_SEL=latched opcode. If CNT==0, capture RESULT/CARRY/ZERO/ERR and go to DONE; otherwise decrement CNT.
- DONE: OUT_VALID=1. RESULT and flags stay stable. On an edge with OUT_VALID&OUT_READY, go to IDLE.
- Functions (B = selected operand):
  - FORWARD: RESULT=B.
  - ADD: RESULT=(A+B) mod 2^WIDTH, CARRY=bit WIDTH of the sum.
  - AND: A&B.
  - OR: A|B.
  - CARRY=0 for all non-ADD operations.
- Illegal opcode (4-7): RESULT=0, ERR=1, ZERO=0, CARRY=0. It still completes the DONE handshake.
- MUX_SEL and ALU_SEL hold their latched values from LOAD through DONE and are 0 in IDLE.
- Inputs that change after acceptance have no effect on the in-flight operation.
- IN_VALID asserted outside IDLE is ignored and nothing is captured. The requester must hold the request until IN_READY.

## Timing
- While RESET is high or after RESET asserts: state=IDLE, CNT=0, and the following outputs are 0: RESULT, CARRY, ZERO, ERR, OUT_VALID, MUX_SEL, ALU_SEL, BUSY. IN_READY=0 while RESET is high and 1 from the first cycle after release.
- Accept at edge n → LOAD after n, EXEC after n+1, OUT_VALID high after edge n+1+EXEC_CYCLES (n+2 with the default).
- If OUT_READY is already high, DONE lasts exactly one cycle. If OUT_READY stays low, DONE persists indefinitely with outputs frozen.
- Result handshake at edge m → IDLE after m. The earliest next accept is edge m+1. Minimum issue interval is EXEC_CYCLES+3 cycles. There is no bypass from DONE to LOAD.
- IN_READY and OUT_VALID are never high in the same cycle.
- RESET asserted mid-LOAD/EXEC/DONE aborts the operation immediately. No OUT_VALID pulse occurs and the in-flight operation is discarded.
- RESULT, CARRY, ZERO and ERR keep the last captured values in IDLE until the next capture.

## Test plan
- Reset: assert RESET mid-simulation → all outputs 0 and IN_READY=0 immediately; release → IN_READY=1 next cycle.
- ADD with a register operand: DATA1=8'h07, DATA2=8'h03, IMM_SEL=0, OUTPUT_READY=1 → RESULT=8'h0A, CARRY=0, ZERO=0, OUT_VALID exactly 2 edges after accept, one cycle wide.
- ADD with wrap and immediate: DATA1=8'hFF, IMM=8'h01, IMM_SEL=1 → MUX_SEL=1 during LOAD..DONE, RESULT=8'h00, CARRY=1, ZERO=1.
- AND/OR/FORWARD with A=8'h07, B=8'h03: AND → 8'h03, OR → 8'h07, FORWARD → 8'h03. Opcode 5 → ERR=1, RESULT=0.
- Backpressure and busy requests: EXEC_CYCLES=4, OUT_READY low for 10 cycles, IN_VALID held high with changing data → no second accept, RESULT stable, accept resumes the cycle after the DONE handshake.
- Reset mid-EXEC: EXEC_CYCLES=4, assert RESET in the 2nd EXEC cycle → state IDLE, OUT_VALID never pulses, next request completes normally.
